program_counter: RTL and testbench



---
 rtl/pc_pkg.sv | 10 +
 rtl/program_counter_if.sv | 37 +++
 rtl/program_counter.sv | 32 +++
 tb/tb_program_counter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared program-counter definitions for the RISC-Z fetch, branch and
// next-PC logic: address width, reset vector and the PC type.
package pc_pkg;

  localparam int PC_WIDTH = 10;
  localparam int PC_RESET_VALUE = 0;

  typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/program_counter_if.sv
// Next-PC / current-PC bus between the upstream next-PC mux (master)
// and the program-counter register (slave). The stall line exists only
// when PC_STALL_EN is defined.
interface program_counter_if #(
  parameter int WIDTH = pc_pkg::PC_WIDTH
) ();

  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;

`ifdef PC_STALL_EN
  logic stall;

  modport master (
    output in,
    output stall,
    input  out
  );

  modport slave (
    input  in,
    input  stall,
    output out
  );
`else
  modport master (
    output in,
    input  out
  );

  modport slave (
    input  in,
    output out
  );
`endif

endinterface

// File: rtl/program_counter.sv
// RISC-Z program counter: a single register that captures the next-PC
// value on every rising edge. No address arithmetic happens here.
// Optional feature macro: PC_STALL_EN adds a stall input that holds the PC.
module program_counter
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET_VALUE)
) (
  input logic clk,
  input logic rst,
  program_counter_if.slave bus
);

  logic [WIDTH-1:0] pc_p0;

  // PC register: reset beats stall, stall beats load; in is taken verbatim.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0 <= RESET_VALUE;
`ifdef PC_STALL_EN
    end else if (bus.stall) begin
      pc_p0 <= pc_p0;
`endif
    end else begin
      pc_p0 <= bus.in;
    end
  end

  assign bus.out = pc_p0;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: default instance plus one built
// with a non-default reset vector (0x3F0). Stall steps are compiled in
// only when PC_STALL_EN is defined.
module tb_program_counter;

  logic clk;
  logic rst;
  int compares;
  int fails;

  program_counter_if #(.WIDTH(10)) b0 ();
  program_counter_if #(.WIDTH(10)) b1 ();

  program_counter #(.WIDTH(10)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  program_counter #(.WIDTH(10), .RESET_VALUE(10'h3F0)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] v);
    b0.in = v;
    b1.in = v;
  endtask

  initial begin
    compares = 0;
    fails = 0;
    rst = 1'b1;
    drive(10'd0);
`ifdef PC_STALL_EN
    b0.stall = 1'b0;
    b1.stall = 1'b0;
`endif

    // reset state
    step();
    check("reset_default", b0.out, 10'd0);
    check("reset_3f0", b1.out, 10'h3F0);

    // basic load
    rst = 1'b0;
    drive(10'd682);
    step();
    check("load_682", b0.out, 10'd682);
    check("load_682_u1", b1.out, 10'd682);
    drive(10'd1023);
    step();
    check("load_1023", b0.out, 10'd1023);
    drive(10'd0);
    step();
    check("load_0_wrap", b0.out, 10'd0);

    // synchronous reset
    drive(10'd1023);
    step();
    check("pre_reset", b0.out, 10'd1023);
    #5;
    rst = 1'b1;
    #2;
    check("rst_midcycle_hold", b0.out, 10'd1023);
    check("rst_midcycle_hold_u1", b1.out, 10'd1023);
    step();
    check("rst_edge", b0.out, 10'd0);
    check("rst_edge_u1", b1.out, 10'h3F0);
    rst = 1'b0;
    step();
    check("rst_release", b0.out, 10'd1023);

    // mid-cycle glitch on in
    drive(10'd5);
    #2;
    drive(10'd9);
    #2;
    check("glitch_no_comb", b0.out, 10'd1023);
    drive(10'd5);
    step();
    check("glitch_capture", b0.out, 10'd5);

    // boundary values
    drive(10'd1023);
    step();
    check("bound_1023", b0.out, 10'd1023);
    drive(10'd0);
    step();
    check("bound_0", b0.out, 10'd0);
    drive(10'd1);
    step();
    check("bound_1", b0.out, 10'd1);
    drive(10'h155);
    step();
    check("pattern_155", b0.out, 10'h155);

`ifdef PC_STALL_EN
    // stall hold and release
    drive(10'd100);
    step();
    check("stall_pre", b0.out, 10'd100);
    b0.stall = 1'b1;
    b1.stall = 1'b1;
    drive(10'd101);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", b0.out, 10'd100);
    end
    b0.stall = 1'b0;
    b1.stall = 1'b0;
    step();
    check("stall_release", b0.out, 10'd101);
    b0.stall = 1'b1;
    b1.stall = 1'b1;
    rst = 1'b1;
    step();
    check("stall_rst", b0.out, 10'd0);
    check("stall_rst_u1", b1.out, 10'h3F0);
    rst = 1'b0;
    b0.stall = 1'b0;
    b1.stall = 1'b0;
`endif

    // final load after all modes
    drive(10'd777);
    step();
    check("final_load", b0.out, 10'd777);
    check("final_load_u1", b1.out, 10'd777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
